// File: rtl/cache_arbiter_pkg.sv
// Shared types for the two-port cache arbiter: FSM states, owner encoding and
// the latched request record presented to the cache.
package cache_arbiter_pkg;

  typedef enum logic [1:0] {
    Idle    = 2'd0,
    Setup   = 2'd1,
    Access  = 2'd2,
    Release = 2'd3
  } state_e;

  localparam logic OWNER_INSTRUCTION = 1'b0;
  localparam logic OWNER_DATA        = 1'b1;

  typedef struct packed {
    logic [31:0] address;
    logic [31:0] data;
    logic [3:0]  we;
  } req_t;

  // Round-robin pick: a tie goes to the port that was not served last.
  function automatic logic rr_pick(input logic i_req, input logic d_req,
                                   input logic last_owner);
    return (i_req && d_req) ? ~last_owner : d_req;
  endfunction

endpackage

// File: rtl/cache_arbiter.sv
// Shares one cache between the instruction-fetch and data ports. Every access
// runs Idle -> Setup -> Access -> Release from a latched request register.
module cache_arbiter
  import cache_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_enable,
  input  logic [31:0] i_address,
  output logic [31:0] i_data_out,
  output logic        i_data_out_ready,
  output logic        i_busy,
  input  logic        d_enable,
  input  logic [31:0] d_address,
  input  logic [31:0] d_data_in,
  input  logic [3:0]  d_write_enable,
  output logic [31:0] d_data_out,
  output logic        d_data_out_ready,
  output logic        d_busy,
  output logic        cache_enable,
  output logic [31:0] cache_address,
  output logic [31:0] cache_data_in,
  output logic [3:0]  cache_write_enable,
  input  logic [31:0] cache_data_out,
  input  logic        cache_data_out_ready,
  input  logic        cache_busy
);

  state_e state;
  req_t   req;
  logic   owner;
  logic   last_owner;
  logic   dropped;

  logic   grant_any;
  logic   grant_owner;
  logic   owner_en;
  logic   served;
  logic   i_served;
  logic   d_served;

  always_comb begin
    grant_any   = i_enable | d_enable;
    grant_owner = rr_pick(i_enable, d_enable, last_owner);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= Idle;
      req        <= '0;
      owner      <= OWNER_INSTRUCTION;
      last_owner <= OWNER_DATA;
      dropped    <= 1'b0;
    end else begin
      case (state)
        Idle: begin
          if (grant_any) begin
            owner   <= grant_owner;
            dropped <= 1'b0;
            if (grant_owner == OWNER_DATA)
              req <= '{address: d_address, data: d_data_in, we: d_write_enable};
            else
              req <= '{address: i_address, data: 32'h0, we: 4'h0};
            state   <= Setup;
          end
        end
        Setup: state <= Access;
        Access: begin
          // A line fill or eviction must run to completion even if the owner
          // walks away; remember that so its result is never delivered.
          if (!owner_en) dropped <= 1'b1;
          if (!cache_busy) begin
            last_owner <= owner;
            state      <= Release;
          end
        end
        Release: state <= Idle;
        default: state <= Idle;
      endcase
    end
  end

  always_comb begin
    cache_enable       = (state == Access);
    cache_address      = req.address;
    cache_data_in      = req.data;
    cache_write_enable = cache_enable ? req.we : 4'h0;
  end

  always_comb begin
    owner_en = (owner == OWNER_DATA) ? d_enable : i_enable;
    served   = cache_enable && owner_en && !dropped;
    i_served = served && (owner == OWNER_INSTRUCTION);
    d_served = served && (owner == OWNER_DATA);

    i_busy           = i_served ? cache_busy : i_enable;
    i_data_out_ready = i_served & cache_data_out_ready;
    i_data_out       = cache_data_out;

    d_busy           = d_served ? cache_busy : d_enable;
    d_data_out_ready = d_served & cache_data_out_ready;
    d_data_out       = cache_data_out;
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a transaction-level model.
module tb_cache_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_enable;
  logic [31:0] i_address;
  logic [31:0] i_data_out;
  logic        i_data_out_ready;
  logic        i_busy;
  logic        d_enable;
  logic [31:0] d_address;
  logic [31:0] d_data_in;
  logic [3:0]  d_write_enable;
  logic [31:0] d_data_out;
  logic        d_data_out_ready;
  logic        d_busy;
  logic        cache_enable;
  logic [31:0] cache_address;
  logic [31:0] cache_data_in;
  logic [3:0]  cache_write_enable;
  logic [31:0] cache_data_out;
  logic        cache_data_out_ready;
  logic        cache_busy;

  int n_vec = 0;
  int n_err = 0;

  cache_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_enable(i_enable), .i_address(i_address), .i_data_out(i_data_out),
    .i_data_out_ready(i_data_out_ready), .i_busy(i_busy),
    .d_enable(d_enable), .d_address(d_address), .d_data_in(d_data_in),
    .d_write_enable(d_write_enable), .d_data_out(d_data_out),
    .d_data_out_ready(d_data_out_ready), .d_busy(d_busy),
    .cache_enable(cache_enable), .cache_address(cache_address),
    .cache_data_in(cache_data_in), .cache_write_enable(cache_write_enable),
    .cache_data_out(cache_data_out), .cache_data_out_ready(cache_data_out_ready),
    .cache_busy(cache_busy)
  );

  always #5 clk = ~clk;

  // Stand-in cache: busy for miss_lat cycles of enable, then completes.
  int          miss_lat = 0;
  int          acc_cnt;
  logic [31:0] rdata = 32'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)            acc_cnt <= 0;
    else if (cache_enable) acc_cnt <= acc_cnt + 1;
    else                   acc_cnt <= 0;
  end

  assign cache_busy           = cache_enable && (acc_cnt < miss_lat);
  assign cache_data_out_ready = cache_enable && !cache_busy && (cache_write_enable == 4'h0);
  assign cache_data_out       = rdata;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: one outstanding grant, aged in cycles since the grant
  // edge; cycles 2.. until the cache stops being busy are the cache access.
  bit          m_act, m_own, m_fin, m_aband, m_last;
  int          m_age;
  logic [31:0] m_addr, m_data;
  logic [3:0]  m_we;
  bit          in_acc, srv;
  logic [1:0]  en;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_act = 0; m_own = 0; m_fin = 0; m_aband = 0; m_last = 1; m_age = 0;
      m_addr = '0; m_data = '0; m_we = '0;
    end
    en     = {d_enable, i_enable};
    in_acc = m_act && (m_age >= 2) && !m_fin;
    srv    = in_acc && en[m_own] && !m_aband;

    chk("m_cache_enable", 64'(cache_enable), 64'(in_acc));
    chk("m_cache_address", 64'(cache_address), 64'(m_addr));
    chk("m_cache_data_in", 64'(cache_data_in), 64'(m_data));
    chk("m_cache_we", 64'(cache_write_enable), 64'(in_acc ? m_we : 4'h0));
    if (srv && m_own == 1'b0) begin
      chk("m_i_busy", 64'(i_busy), 64'(cache_busy));
      chk("m_i_ready", 64'(i_data_out_ready), 64'(cache_data_out_ready));
      if (cache_data_out_ready) chk("m_i_data", 64'(i_data_out), 64'(rdata));
    end else begin
      chk("m_i_busy", 64'(i_busy), 64'(i_enable));
      chk("m_i_ready", 64'(i_data_out_ready), 64'(0));
    end
    if (srv && m_own == 1'b1) begin
      chk("m_d_busy", 64'(d_busy), 64'(cache_busy));
      chk("m_d_ready", 64'(d_data_out_ready), 64'(cache_data_out_ready));
      if (cache_data_out_ready) chk("m_d_data", 64'(d_data_out), 64'(rdata));
    end else begin
      chk("m_d_busy", 64'(d_busy), 64'(d_enable));
      chk("m_d_ready", 64'(d_data_out_ready), 64'(0));
    end

    if (rst_n) begin
      if (!m_act) begin
        if (en != 2'b00) begin
          m_own = (en == 2'b11) ? !m_last : en[1];
          if (m_own) begin m_addr = d_address; m_data = d_data_in; m_we = d_write_enable; end
          else       begin m_addr = i_address; m_data = '0;        m_we = '0;             end
          m_act = 1; m_age = 1; m_fin = 0; m_aband = 0;
        end
      end else if (m_fin) begin
        m_act = 0;
      end else if (m_age == 1) begin
        m_age = 2;
      end else begin
        if (!en[m_own]) m_aband = 1;
        if (!cache_busy) begin m_fin = 1; m_last = m_own; end
      end
    end
  end

  task automatic step(); @(posedge clk); #1; endtask
  task automatic smp();  @(negedge clk);    endtask

  int ce_cnt, rdy_cnt;

  initial begin
    i_enable = 0; i_address = '0; d_enable = 0; d_address = '0;
    d_data_in = '0; d_write_enable = '0;
    repeat (2) smp();
    chk("rst_cache_enable", 64'(cache_enable), 64'(0));
    chk("rst_cache_address", 64'(cache_address), 64'(0));
    chk("rst_i_busy", 64'(i_busy), 64'(0));
    chk("rst_d_busy", 64'(d_busy), 64'(0));
    chk("rst_i_ready", 64'(i_data_out_ready), 64'(0));
    chk("rst_d_ready", 64'(d_data_out_ready), 64'(0));

    // Tie straight out of reset: instruction first, data next.
    @(posedge clk); #1;
    rst_n = 1; i_enable = 1; i_address = 32'h200; d_enable = 1; d_address = 32'h300;
    rdata = 32'hA5A5_0001;
    smp(); chk("tie_t0_i_busy", 64'(i_busy), 64'(1)); chk("tie_t0_d_busy", 64'(d_busy), 64'(1));
    smp(); chk("tie_setup_addr", 64'(cache_address), 64'h200); chk("tie_setup_d_busy", 64'(d_busy), 64'(1));
    smp(); chk("tie_i_ready", 64'(i_data_out_ready), 64'(1)); chk("tie_acc_d_busy", 64'(d_busy), 64'(1));
    step(); i_enable = 0;
    smp(); chk("tie_rel_d_busy", 64'(d_busy), 64'(1));
    smp(); chk("tie_idle_d_busy", 64'(d_busy), 64'(1));
    smp(); chk("tie_d_setup_addr", 64'(cache_address), 64'h300);
    smp(); chk("tie_d_ready", 64'(d_data_out_ready), 64'(1)); chk("tie_d_busy_acc", 64'(d_busy), 64'(0));
    step(); d_enable = 0;

    // Instruction read hit.
    step(); i_enable = 1; i_address = 32'h0000_0040; rdata = 32'hDEAD_BEEF;
    smp();
    smp(); chk("ird_t1_ce", 64'(cache_enable), 64'(0)); chk("ird_t1_addr", 64'(cache_address), 64'h40);
    smp(); chk("ird_t2_ready", 64'(i_data_out_ready), 64'(1)); chk("ird_t2_data", 64'(i_data_out), 64'hDEAD_BEEF);
    step(); i_enable = 0;
    smp(); chk("ird_t3_ce", 64'(cache_enable), 64'(0)); chk("ird_t3_ready", 64'(i_data_out_ready), 64'(0));

    // Data write with partial mask.
    step(); d_enable = 1; d_address = 32'h100; d_data_in = 32'h1234_5678; d_write_enable = 4'b0011;
    smp();
    smp(); chk("wr_setup_we", 64'(cache_write_enable), 64'(0));
    smp(); chk("wr_acc_we", 64'(cache_write_enable), 64'b0011);
    chk("wr_acc_data", 64'(cache_data_in), 64'h1234_5678);
    chk("wr_acc_d_busy", 64'(d_busy), 64'(0)); chk("wr_acc_ready", 64'(d_data_out_ready), 64'(0));
    step(); d_enable = 0;
    smp(); chk("wr_rel_we", 64'(cache_write_enable), 64'(0));

    // 20-cycle miss: stays in access with a stable address.
    step(); miss_lat = 20; i_enable = 1; i_address = 32'h0000_0ABC; rdata = 32'hCAFE_0123;
    smp(); smp();
    ce_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      smp();
      if (cache_enable && cache_address == 32'hABC && i_busy) ce_cnt++;
    end
    chk("miss_hold_cycles", 64'(ce_cnt), 64'(20));
    smp(); chk("miss_ready", 64'(i_data_out_ready), 64'(1)); chk("miss_busy", 64'(i_busy), 64'(0));
    step(); i_enable = 0;
    smp(); chk("miss_rel_addr", 64'(cache_address), 64'hABC); chk("miss_rel_ce", 64'(cache_enable), 64'(0));

    // Owner abandons a 20-cycle miss five cycles in.
    step(); i_enable = 1; i_address = 32'h0000_0DD0;
    smp(); smp();
    ce_cnt = 0; rdy_cnt = 0;
    for (int k = 0; k < 25; k++) begin
      smp();
      if (cache_enable) ce_cnt++;
      if (i_data_out_ready) rdy_cnt++;
      step();
      if (k == 4) i_enable = 0;
    end
    chk("drop_ce_cycles", 64'(ce_cnt), 64'(21));
    chk("drop_no_ready", 64'(rdy_cnt), 64'(0));
    miss_lat = 0;

    // Randomized traffic, including a stretch with both ports always asking.
    for (int n = 0; n < 400; n++) begin
      step();
      if (!cache_enable) miss_lat = $urandom_range(0, 3);
      if (n >= 200 && n < 260) begin
        i_enable = 1; d_enable = 1;
      end else begin
        i_enable = ($urandom_range(0, 9) < 7);
        d_enable = ($urandom_range(0, 9) < 7);
      end
      i_address = $urandom; d_address = $urandom; d_data_in = $urandom; rdata = $urandom;
      d_write_enable = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
    end
    step(); i_enable = 0; d_enable = 0;
    repeat (10) step();

    // Reset in the middle of an access, then a tie again favours instruction.
    miss_lat = 20; i_enable = 1; i_address = 32'h777;
    smp(); smp();
    smp(); chk("rstacc_ce", 64'(cache_enable), 64'(1));
    step(); rst_n = 0; i_enable = 0;
    smp();
    chk("rstacc_ce0", 64'(cache_enable), 64'(0));
    chk("rstacc_addr0", 64'(cache_address), 64'(0));
    chk("rstacc_we0", 64'(cache_write_enable), 64'(0));
    chk("rstacc_din0", 64'(cache_data_in), 64'(0));
    chk("rstacc_busy0", 64'({i_busy, d_busy}), 64'(0));
    chk("rstacc_rdy0", 64'({i_data_out_ready, d_data_out_ready}), 64'(0));
    step(); rst_n = 1; miss_lat = 0; i_enable = 1; d_enable = 1;
    i_address = 32'h44; d_address = 32'h88; d_write_enable = 4'h0;
    smp();
    smp(); chk("rst_tie_addr", 64'(cache_address), 64'h44);
    smp(); chk("rst_tie_i_ready", 64'(i_data_out_ready), 64'(1));
    step(); i_enable = 0;
    smp(); smp();
    smp(); chk("rst_tie_d_addr", 64'(cache_address), 64'h88);
    smp(); chk("rst_tie_d_ready", 64'(d_data_out_ready), 64'(1));
    step(); d_enable = 0;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
